// File: rtl/dpbus_pkg.sv
// Shared constants, helper function and FIFO entry type for the datapath bus receiver.
package dpbus_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NDRV  = 4;
  localparam int DEF_DEPTH = 2;

  // Ceiling log2 for elaboration-time sizing (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int DEF_SRCW = clog2(DEF_NDRV);

  // One buffered bus word with the index of the driver that produced it.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SRCW-1:0]  src;
  } dpbus_entry_t;

endpackage

// File: rtl/dpbus_rcv_if.sv
// Bus-side inputs and consumer-side outputs of the datapath bus receiver.
interface dpbus_rcv_if
  import dpbus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDRV  = DEF_NDRV,
  parameter int SRCW  = clog2(DEF_NDRV)
);
  logic [WIDTH-1:0] bus;
  logic [NDRV-1:0]  bus_en_n;
  logic             cap_n;
  logic             rd;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic [SRCW-1:0]  dsrc;
  logic             dvalid;
  logic             full;
  logic             cont;
  logic             float;
  logic             ovr;

  modport master (
    output bus, bus_en_n, cap_n, rd, clr,
    input  dout, dsrc, dvalid, full, cont, float, ovr
  );

  modport slave (
    input  bus, bus_en_n, cap_n, rd, clr,
    output dout, dsrc, dvalid, full, cont, float, ovr
  );
endinterface

// File: rtl/dpbus_endec.sv
// Decodes the active-low driver enables: exactly one, none, or several drivers on the bus.
module dpbus_endec
  import dpbus_pkg::*;
#(
  parameter int NDRV = DEF_NDRV,
  parameter int SRCW = clog2(NDRV)
) (
  input  logic [NDRV-1:0] en_n,
  output logic            one,
  output logic            none,
  output logic            multi,
  output logic [SRCW-1:0] idx
);
  localparam int CW = clog2(NDRV + 1);

  logic [CW-1:0] nlow_s;

  // Count the low enables and remember the position of the (last) low one.
  always_comb begin
    nlow_s = '0;
    idx    = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (!en_n[i]) begin
        nlow_s = nlow_s + CW'(1'b1);
        idx    = SRCW'(i);
      end else begin
        nlow_s = nlow_s;
      end
    end
    one   = (nlow_s == CW'(1'b1));
    none  = (nlow_s == '0);
    multi = !one && !none;
  end
endmodule

// File: rtl/dpbus_rcv.sv
// Datapath tristate bus receiver: captures on a strobe, tags with the driver index,
// buffers in a small FIFO and reports contention/float/overrun as sticky flags.
module dpbus_rcv
  import dpbus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDRV  = DEF_NDRV,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SRCW  = clog2(NDRV)
) (
  input logic        clk,
  input logic        rst_n,
  dpbus_rcv_if.slave bif
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SRCW-1:0]  src;
  } entry_t;

  entry_t          mem_r [DEPTH];
  entry_t          head_r, head_nxt_s, entry_in_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r, count_s, count_nxt_s;
  logic [AW-1:0]   rd_next_idx_s;
  logic            dvalid_r, full_r, cont_r, float_r, ovr_r;
  logic            cap_s, push_s, pop_s, drop_s, empty_s, full_s;
  logic            one_s, none_s, multi_s;
  logic [SRCW-1:0] idx_s;

  dpbus_endec #(.NDRV(NDRV), .SRCW(SRCW)) u_endec (
    .en_n  (bif.bus_en_n),
    .one   (one_s),
    .none  (none_s),
    .multi (multi_s),
    .idx   (idx_s)
  );

  // Push/pop qualification and the entry that will sit at the head after this edge.
  // The head is kept in its own register so an empty FIFO still shows the last popped word.
  always_comb begin
    count_s       = wr_ptr_r - rd_ptr_r;
    empty_s       = (wr_ptr_r == rd_ptr_r);
    full_s        = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                    (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
    cap_s         = !bif.cap_n;
    pop_s         = bif.rd && !empty_s;
    push_s        = cap_s && one_s && (!full_s || pop_s);
    drop_s        = cap_s && one_s && full_s && !pop_s;
    entry_in_s    = '{data: bif.bus, src: idx_s};
    count_nxt_s   = count_s + {{(PW-1){1'b0}}, push_s} - {{(PW-1){1'b0}}, pop_s};
    rd_next_idx_s = rd_ptr_r[AW-1:0] + AW'(1'b1);
    head_nxt_s    = head_r;
    if (empty_s) begin
      if (push_s) begin
        head_nxt_s = entry_in_s;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (pop_s) begin
      if (count_s == PW'(1'b1)) begin
        if (push_s) begin
          head_nxt_s = entry_in_s;
        end else begin
          head_nxt_s = head_r;
        end
      end else begin
        head_nxt_s = mem_r[rd_next_idx_s];
      end
    end else begin
      head_nxt_s = head_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= entry_in_s;
    end
  end

  // Pointers, head register and occupancy status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
      dvalid_r <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      head_r   <= head_nxt_s;
      dvalid_r <= (count_nxt_s != '0);
      full_r   <= (count_nxt_s == PW'(DEPTH));
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_r  <= 1'b0;
      float_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      cont_r  <= (cap_s && multi_s) || (cont_r && !bif.clr);
      float_r <= (cap_s && none_s)  || (float_r && !bif.clr);
      ovr_r   <= drop_s             || (ovr_r && !bif.clr);
    end
  end

  assign bif.dout   = head_r.data;
  assign bif.dsrc   = head_r.src;
  assign bif.dvalid = dvalid_r;
  assign bif.full   = full_r;
  assign bif.cont   = cont_r;
  assign bif.float  = float_r;
  assign bif.ovr    = ovr_r;
endmodule

// File: tb/tb_dpbus_rcv.sv
// Directed self-checking bench for dpbus_rcv.
module tb_dpbus_rcv;
  import dpbus_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dpbus_rcv_if #(.WIDTH(32), .NDRV(4), .SRCW(2)) bif ();

  dpbus_rcv #(.WIDTH(32), .NDRV(4), .DEPTH(2), .SRCW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.bus      = 32'h0;
    bif.bus_en_n = 4'b1111;
    bif.cap_n    = 1'b1;
    bif.rd       = 1'b0;
    bif.clr      = 1'b0;
  endtask

  task automatic capture(input logic [31:0] data, input logic [3:0] en_n);
    bif.bus      = data;
    bif.bus_en_n = en_n;
    bif.cap_n    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    n_checks++; if ({bif.dout, bif.dsrc, bif.dvalid, bif.full, bif.cont, bif.float, bif.ovr} !== 39'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {bif.dout, bif.dsrc, bif.dvalid, bif.full, bif.cont, bif.float, bif.ovr}); end
    // load a word and a float flag, then reset mid-cycle
    capture(32'h12345678, 4'b1110); cycle();
    capture(32'h0, 4'b1111); cycle();
    idle();
    n_checks++; if (bif.dvalid !== 1'b1 || bif.float !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: dvalid=%b float=%b required 1 1", bif.dvalid, bif.float); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({bif.dout, bif.dsrc, bif.dvalid, bif.full, bif.cont, bif.float, bif.ovr} !== 39'h0) begin
      n_fail++; $display("FAIL async_reset: got %h required 0", {bif.dout, bif.dsrc, bif.dvalid, bif.full, bif.cont, bif.float, bif.ovr}); end
    cycle();
    rst_n = 1'b1;
    bif.rd = 1'b1;
    cycle(); cycle();
    bif.rd = 1'b0;
    n_checks++; if (bif.dvalid !== 1'b0 || bif.dout !== 32'h0) begin
      n_fail++; $display("FAIL rd_when_empty: dvalid=%b dout=%h required 0 0", bif.dvalid, bif.dout); end
  endtask

  task automatic test_single();
    capture(32'hDEADBEEF, 4'b1011); cycle(); idle();
    n_checks++; if (bif.dout !== 32'hDEADBEEF || bif.dsrc !== 2'd2 || bif.dvalid !== 1'b1 || bif.full !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: dout=%h dsrc=%0d dvalid=%b full=%b required deadbeef 2 1 0", bif.dout, bif.dsrc, bif.dvalid, bif.full); end
    bif.rd = 1'b1; cycle(); bif.rd = 1'b0;
    n_checks++; if (bif.dvalid !== 1'b0 || bif.dout !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_pop: dvalid=%b dout=%h required 0 deadbeef", bif.dvalid, bif.dout); end
  endtask

  task automatic test_overrun();
    capture(32'hAAAA0001, 4'b1110); cycle();
    capture(32'hBBBB0002, 4'b1101); cycle();
    n_checks++; if (bif.full !== 1'b1 || bif.dout !== 32'hAAAA0001 || bif.dsrc !== 2'd0) begin
      n_fail++; $display("FAIL full_after_two: full=%b dout=%h dsrc=%0d required 1 aaaa0001 0", bif.full, bif.dout, bif.dsrc); end
    capture(32'hCCCC0003, 4'b0111); cycle(); idle();
    n_checks++; if (bif.ovr !== 1'b1 || bif.full !== 1'b1 || bif.dout !== 32'hAAAA0001) begin
      n_fail++; $display("FAIL overrun: ovr=%b full=%b dout=%h required 1 1 aaaa0001", bif.ovr, bif.full, bif.dout); end
    bif.rd = 1'b1; cycle();
    n_checks++; if (bif.dout !== 32'hBBBB0002 || bif.dsrc !== 2'd1 || bif.dvalid !== 1'b1 || bif.full !== 1'b0) begin
      n_fail++; $display("FAIL overrun_pop_b: dout=%h dsrc=%0d dvalid=%b full=%b required bbbb0002 1 1 0", bif.dout, bif.dsrc, bif.dvalid, bif.full); end
    cycle(); bif.rd = 1'b0;
    n_checks++; if (bif.dvalid !== 1'b0) begin
      n_fail++; $display("FAIL overrun_drained: dvalid=%b required 0", bif.dvalid); end
    bif.clr = 1'b1; cycle(); bif.clr = 1'b0;
    n_checks++; if (bif.ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: ovr=%b required 0", bif.ovr); end
  endtask

  task automatic test_full_push_pop();
    capture(32'h0000000A, 4'b1110); cycle();
    capture(32'h0000000B, 4'b1101); cycle();
    capture(32'h0000000C, 4'b1011); bif.rd = 1'b1; cycle(); idle();
    n_checks++; if (bif.dout !== 32'h0000000B || bif.dsrc !== 2'd1 || bif.full !== 1'b1 || bif.ovr !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop: dout=%h dsrc=%0d full=%b ovr=%b required b 1 1 0", bif.dout, bif.dsrc, bif.full, bif.ovr); end
    bif.rd = 1'b1; cycle();
    n_checks++; if (bif.dout !== 32'h0000000C || bif.dsrc !== 2'd2 || bif.dvalid !== 1'b1 || bif.full !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop_c: dout=%h dsrc=%0d dvalid=%b full=%b required c 2 1 0", bif.dout, bif.dsrc, bif.dvalid, bif.full); end
    cycle(); bif.rd = 1'b0;
    n_checks++; if (bif.dvalid !== 1'b0 || bif.dout !== 32'h0000000C) begin
      n_fail++; $display("FAIL full_push_pop_drain: dvalid=%b dout=%h required 0 c", bif.dvalid, bif.dout); end
  endtask

  task automatic test_flags();
    capture(32'h11111111, 4'b0101); cycle(); idle();
    n_checks++; if (bif.cont !== 1'b1 || bif.float !== 1'b0 || bif.dvalid !== 1'b0) begin
      n_fail++; $display("FAIL contention: cont=%b float=%b dvalid=%b required 1 0 0", bif.cont, bif.float, bif.dvalid); end
    capture(32'h22222222, 4'b1111); cycle(); idle();
    n_checks++; if (bif.float !== 1'b1 || bif.cont !== 1'b1 || bif.dvalid !== 1'b0) begin
      n_fail++; $display("FAIL float: float=%b cont=%b dvalid=%b required 1 1 0", bif.float, bif.cont, bif.dvalid); end
    bif.clr = 1'b1; cycle();
    n_checks++; if (bif.cont !== 1'b0 || bif.float !== 1'b0) begin
      n_fail++; $display("FAIL flag_clear: cont=%b float=%b required 0 0", bif.cont, bif.float); end
    capture(32'h33333333, 4'b0101); bif.clr = 1'b1; cycle(); idle();
    n_checks++; if (bif.cont !== 1'b1 || bif.dvalid !== 1'b0) begin
      n_fail++; $display("FAIL clr_vs_event: cont=%b dvalid=%b required 1 0", bif.cont, bif.dvalid); end
    bif.clr = 1'b1; cycle(); bif.clr = 1'b0;
    n_checks++; if (bif.cont !== 1'b0) begin
      n_fail++; $display("FAIL flag_clear2: cont=%b required 0", bif.cont); end
  endtask

  task automatic test_wrap();
    dpbus_entry_t exp;
    logic [3:0]   en_n;
    for (int i = 0; i < 10; i++) begin
      exp.data = 32'(i);
      exp.src  = 2'(i % 4);
      en_n     = ~(4'b0001 << exp.src);
      capture(exp.data, en_n); cycle(); idle();
      n_checks++; if (bif.dout !== exp.data || bif.dsrc !== exp.src || bif.dvalid !== 1'b1 || bif.full !== 1'b0) begin
        n_fail++; $display("FAIL wrap_push[%0d]: dout=%h dsrc=%0d dvalid=%b full=%b required %h %0d 1 0", i, bif.dout, bif.dsrc, bif.dvalid, bif.full, exp.data, exp.src); end
      bif.rd = 1'b1; cycle(); bif.rd = 1'b0;
      n_checks++; if (bif.dvalid !== 1'b0 || {bif.cont, bif.float, bif.ovr} !== 3'b000) begin
        n_fail++; $display("FAIL wrap_pop[%0d]: dvalid=%b flags=%b required 0 000", i, bif.dvalid, {bif.cont, bif.float, bif.ovr}); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_overrun();
    test_full_push_pop();
    test_flags();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dpbus_rcv.md
Name: dpbus_rcv

Overview:
- Receiving end of the shared datapath tristate bus. The bus is driven by NDRV tristate bit-slice drivers, each with an active-low enable.
- Samples the bus on an active-low capture strobe and tags each word with the index of the driver that produced it.
- Buffers captured words in a small FIFO and hands them to the consumer over a valid/ready handshake.
- Reports contention, float and overrun as sticky flags.

Parameters:
- WIDTH, 32, bus data width in bits.
- NDRV, 4, number of tristate drivers on the bus (2..16).
- DEPTH, 2, FIFO entries, power of 2, at least 2.
- SRCW, 2, source-index width; must equal ceil(log2(NDRV)).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BUS  in  WIDTH  shared tristate bus value.
- BUS_EN_N  in  NDRV  copies of the per-driver active-low enables; bit i low means driver i is driving.
- CAP_N  in  1  active-low capture strobe.
- RD  in  1  consumer ready.
- CLR  in  1  clears the sticky flags.
- DOUT  out  WIDTH  head-of-FIFO data.
- DSRC  out  SRCW  driver index of the head word.
- DVALID  out  1  FIFO not empty.
- FULL  out  1  FIFO holds DEPTH entries.
- CONT  out  1  sticky: capture attempted while more than one driver was enabled.
- FLOAT  out  1  sticky: capture attempted while no driver was enabled.
- OVR  out  1  sticky: word dropped because the FIFO was full.

Behaviour:
- Reset:
  - RESET_N low clears everything immediately (asynchronous): pointers, count, DOUT, DSRC, DVALID, FULL, CONT, FLOAT, OVR all go to 0.
  - A capture in flight when reset asserts is lost.
- Enable decode (combinational, per cycle), with nlow = number of zero bits in BUS_EN_N:
  - nlow==1: capture is valid; idx = position of the zero bit.
  - nlow==0: float case.
  - nlow>1: contention case.
- Push: when CAP_N==0 and nlow==1, write {BUS, idx} at the write pointer.
  - Suppressed if FULL and no pop occurs in the same cycle; in that case set OVR.
- Capture with nlow==0: no push; set FLOAT.
- Capture with nlow>1: no push; set CONT.
- Pop: when RD==1 and DVALID==1, advance the read pointer. RD while empty has no effect.
- Simultaneous push and pop:
  - When FULL, the push is accepted, the count is unchanged, and OVR is not set.
  - When empty, push only; the popped-data path is never bypassed.
- Latency: a word captured in cycle N appears on DOUT/DSRC with DVALID=1 in cycle N+1. No combinational path from BUS to DOUT.
- Output hold: DOUT/DSRC always show the head entry. They hold their value while DVALID=1 and RD=0. When empty, they show the last popped entry (0 after reset).
- Pointers: log2(DEPTH)+1 bits wide; wrap modulo 2*DEPTH.
  - FULL: pointers are equal except the MSB.
  - Empty: pointers are fully equal.
- Sticky flags:
  - Set by their event; cleared only by CLR=1 or reset.
  - If CLR and a new event occur in the same cycle, the flag is set (the event wins).
- X/Z on BUS is captured as-is. Float detection is based only on BUS_EN_N, never on the bus value.

Decomposition:
- Package dpbus_pkg:
  - Default WIDTH/NDRV constants.
  - Function clog2.
  - FIFO entry struct {data, src}.
- Sub-module dpbus_endec: combinational.
  - Inputs: BUS_EN_N.
  - Outputs: one-hot-low valid, none, multi, idx.
  - Reused by the bus monitor.
- FIFO storage and the flags live inline in dpbus_rcv.

Test Plan:
1. Reset/empty: RESET_N low mid-cycle -> all outputs 0 immediately. RD=1 while empty -> DVALID stays 0 and DOUT=0.
2. Single capture: BUS=32'hDEADBEEF, BUS_EN_N=4'b1011, CAP_N=0 for 1 cycle -> next cycle DOUT=DEADBEEF, DSRC=2, DVALID=1. RD=1 -> DVALID=0 on the following cycle.
3. Full and overrun: 3 captures (A, B, C) with RD=0 -> FULL=1 after B; C dropped, OVR=1. Pops return A then B in order.
4. Full with simultaneous push and pop: FIFO holds A, B; capture C with RD=1 -> DOUT=B next cycle, FULL stays 1, OVR=0. Subsequent pops return B then C.
5. Contention/float: CAP_N=0 with BUS_EN_N=4'b0101 -> CONT=1, no push. With BUS_EN_N=4'b1111 -> FLOAT=1, no push. CLR=1 clears both. CLR together with a new contention -> CONT stays 1.
6. Wrap-around: 10 alternating push/pop pairs with data 0..9 and rotating source 0..3 -> every output matches the scoreboard; no flag ever set.
